// File: rtl/instruction_loader_if.sv
// Byte-stream input, instruction-memory write port and session status of the loader.
// The loader uses the slave modport; whatever feeds it uses the master modport.
interface instruction_loader_if;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [15:0] words_loaded;

  modport master (
    output start, in_data, in_valid,
    input  in_ready, mem_wr_en, mem_addr, mem_data, busy, done, overflow, words_loaded
  );

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, mem_wr_en, mem_addr, mem_data, busy, done, overflow, words_loaded
  );
endinterface

// File: rtl/instruction_loader.sv
// Loads a length-prefixed big-endian byte stream into instruction memory, one word per WRITE cycle.
// Words past DEPTH are still consumed, but their write is suppressed and overflow is flagged.
module instruction_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instruction_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_len;
  logic [15:0] r_index;
  logic [15:0] r_wordsLoaded;
  logic [1:0]  r_byteCnt;
  logic [23:0] r_word;
  logic        r_memWrEn;
  logic        r_overflow;
  logic [31:0] r_memAddr;
  logic [31:0] r_memData;

  logic        w_inReady;
  logic        w_busy;
  logic        w_done;
  logic        w_xfer;
  logic        w_inRange;
  logic [15:0] w_indexNext;

  assign w_indexNext = r_index + 16'd1;
  assign w_inRange   = ({16'd0, r_index} < DEPTH);
  assign w_xfer      = bus.in_valid && w_inReady;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // in_ready is a pure state decode, so in_valid never reaches it combinationally.
  always_comb begin
    w_next    = r_state;
    w_inReady = 1'b0;
    w_busy    = 1'b0;
    w_done    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        w_inReady = 1'b1;
        w_busy    = 1'b1;
        if (bus.in_valid) w_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        w_inReady = 1'b1;
        w_busy    = 1'b1;
        if (bus.in_valid)
          w_next = ({r_len[15:8], bus.in_data} == 16'd0) ? S_DONE : S_DATA;
      end
      S_DATA: begin
        w_inReady = 1'b1;
        w_busy    = 1'b1;
        if (bus.in_valid && (r_byteCnt == 2'd3)) w_next = S_WRITE;
      end
      S_WRITE: begin
        w_busy = 1'b1;
        w_next = (w_indexNext == r_len) ? S_DONE : S_DATA;
      end
      S_DONE: begin
        w_done = 1'b1;
        if (bus.start) w_next = S_LEN_HI;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // The write port is loaded on the 4th byte so it is valid during the WRITE cycle and then holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len         <= 16'd0;
      r_index       <= 16'd0;
      r_wordsLoaded <= 16'd0;
      r_byteCnt     <= 2'd0;
      r_word        <= 24'd0;
      r_memWrEn     <= 1'b0;
      r_overflow    <= 1'b0;
      r_memAddr     <= 32'd0;
      r_memData     <= 32'd0;
    end else begin
      r_memWrEn <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_len         <= 16'd0;
            r_index       <= 16'd0;
            r_wordsLoaded <= 16'd0;
            r_byteCnt     <= 2'd0;
            r_overflow    <= 1'b0;
          end
        end
        S_LEN_HI: begin
          if (w_xfer) r_len[15:8] <= bus.in_data;
        end
        S_LEN_LO: begin
          if (w_xfer) r_len[7:0] <= bus.in_data;
        end
        S_DATA: begin
          if (w_xfer) begin
            r_word    <= {r_word[15:0], bus.in_data};
            r_byteCnt <= r_byteCnt + 2'd1;
            if (r_byteCnt == 2'd3) begin
              r_memWrEn <= w_inRange;
              r_memAddr <= BASE_ADDR + {14'd0, r_index, 2'b00};
              r_memData <= {r_word, bus.in_data};
            end
          end
        end
        S_WRITE: begin
          r_index <= w_indexNext;
          if (r_memWrEn) r_wordsLoaded <= r_wordsLoaded + 16'd1;
          else           r_overflow    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready     = w_inReady;
  assign bus.busy         = w_busy;
  assign bus.done         = w_done;
  assign bus.mem_wr_en    = r_memWrEn;
  assign bus.mem_addr     = r_memAddr;
  assign bus.mem_data     = r_memData;
  assign bus.overflow     = r_overflow;
  assign bus.words_loaded = r_wordsLoaded;

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: a byte-count reference model checked every cycle,
// directed sessions with literal expectations, then randomized sessions.
module tb_instruction_loader;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          DEPTH = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  instruction_loader_if lif ();

  instruction_loader #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (lif)
  );

  always #5 clk = ~clk;

  int nCompared   = 0;
  int nMismatched = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t dutWrites[$];

  // Reference model: session progress is tracked only as a count of accepted bytes.
  bit          mActive, mDone, mOverflow, mWrite, mWrEn;
  int          mIndex, mLen, mBytes, mLoaded;
  logic [31:0] mWord, mAddr, mData;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mActive = 0; mDone = 0; mOverflow = 0; mWrite = 0; mWrEn = 0;
    mIndex = 0; mLen = 0; mBytes = 0; mLoaded = 0;
    mWord = '0; mAddr = '0; mData = '0;
  endtask

  task automatic modelStep();
    if (!rst_n) begin
      modelReset();
    end else if (!mActive) begin
      if (lif.start) begin
        mActive = 1; mDone = 0; mOverflow = 0; mLoaded = 0;
        mIndex = 0; mLen = 0; mBytes = 0; mWrite = 0;
      end
    end else if (mWrite) begin
      mWrite = 0;
      if (mWrEn) mLoaded++;
      else       mOverflow = 1;
      mIndex++;
      if (mIndex == mLen) begin mActive = 0; mDone = 1; end
    end else if (lif.in_valid) begin
      if (mBytes == 0) begin
        mLen = int'(lif.in_data) * 256;
      end else if (mBytes == 1) begin
        mLen += int'(lif.in_data);
        if (mLen == 0) begin mActive = 0; mDone = 1; end
      end else begin
        mWord = {mWord[23:0], lif.in_data};
        if ((mBytes - 2) % 4 == 3) begin
          mWrite = 1;
          mWrEn  = (mIndex < DEPTH);
          mAddr  = BASE + 32'(4 * mIndex);
          mData  = mWord;
        end
      end
      mBytes++;
    end
  endtask

  initial modelReset();

  always @(negedge clk) begin
    if (!rst_n) modelReset();
    checkOutput("in_ready",     32'(lif.in_ready),     32'(mActive && !mWrite));
    checkOutput("busy",         32'(lif.busy),         32'(mActive));
    checkOutput("done",         32'(lif.done),         32'(mDone));
    checkOutput("overflow",     32'(lif.overflow),     32'(mOverflow));
    checkOutput("words_loaded", 32'(lif.words_loaded), 32'(mLoaded));
    checkOutput("mem_wr_en",    32'(lif.mem_wr_en),    32'(mWrite && mWrEn));
    if (mWrite && mWrEn) begin
      checkOutput("mem_addr", lif.mem_addr, mAddr);
      checkOutput("mem_data", lif.mem_data, mData);
    end
    if (lif.mem_wr_en) dutWrites.push_back('{lif.mem_addr, lif.mem_data});
    modelStep();
  end

  task automatic pulseStart();
    lif.start = 1'b1;
    @(posedge clk); #2;
    lif.start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input bit gappy);
    bit   taken = 0;
    bit   rdy;
    logic v;
    int   guard = 0;
    while (!taken && guard < 64) begin
      v = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
      lif.in_valid = v;
      lif.in_data  = v ? b : 8'($urandom);
      @(negedge clk);
      rdy = lif.in_ready;
      @(posedge clk); #2;
      taken = v && rdy;
      guard++;
    end
    lif.in_valid = 1'b0;
    if (!taken) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL byte_timeout: got no accept, want accept of 0x%02h", b);
    end
  endtask

  task automatic waitIdle();
    int guard = 0;
    while (lif.busy && guard < 20) begin
      @(posedge clk); #2;
      guard++;
    end
    checkOutput("session_done", 32'(lif.done), 32'd1);
  endtask

  task automatic applyStimulus(input logic [7:0] bytes[$], input bit gappy);
    pulseStart();
    foreach (bytes[i]) sendByte(bytes[i], gappy);
    waitIdle();
  endtask

  task automatic checkWrite(input string name, input int idx, input logic [31:0] addr, input logic [31:0] data);
    if (idx < dutWrites.size()) begin
      checkOutput({name, "_addr"}, dutWrites[idx].addr, addr);
      checkOutput({name, "_data"}, dutWrites[idx].data, data);
    end else begin
      checkOutput({name, "_missing"}, 32'(dutWrites.size()), 32'(idx + 1));
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_in_ready"},  32'(lif.in_ready),     32'd0);
    checkOutput({tag, "_wr_en"},     32'(lif.mem_wr_en),    32'd0);
    checkOutput({tag, "_addr"},      lif.mem_addr,          32'd0);
    checkOutput({tag, "_data"},      lif.mem_data,          32'd0);
    checkOutput({tag, "_busy"},      32'(lif.busy),         32'd0);
    checkOutput({tag, "_done"},      32'(lif.done),         32'd0);
    checkOutput({tag, "_overflow"},  32'(lif.overflow),     32'd0);
    checkOutput({tag, "_loaded"},    32'(lif.words_loaded), 32'd0);
  endtask

  logic [7:0] q[$];

  initial begin
    lif.start    = 1'b0;
    lif.in_valid = 1'b0;
    lif.in_data  = 8'h00;
    #1 rst_n = 1'b0;
    #1 checkAllZero("por");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("idle_busy", 32'(lif.busy), 32'd0);
    checkOutput("idle_done", 32'(lif.done), 32'd0);

    $display("[TB] basic load");
    dutWrites.delete();
    q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h04};
    applyStimulus(q, 1'b0);
    checkOutput("basic_count", 32'(dutWrites.size()), 32'd2);
    checkWrite("basic_w0", 0, 32'h0000_0000, 32'h2008_0005);
    checkWrite("basic_w1", 1, 32'h0000_0004, 32'hAC08_0004);
    checkOutput("basic_loaded", 32'(lif.words_loaded), 32'd2);
    checkOutput("basic_busy",   32'(lif.busy),         32'd0);

    $display("[TB] zero length");
    dutWrites.delete();
    pulseStart();
    sendByte(8'h00, 1'b0);
    checkOutput("zero_done_early", 32'(lif.done), 32'd0);
    sendByte(8'h00, 1'b0);
    checkOutput("zero_done", 32'(lif.done), 32'd1);
    repeat (3) @(posedge clk);
    #2;
    checkOutput("zero_writes", 32'(dutWrites.size()), 32'd0);
    checkOutput("zero_loaded", 32'(lif.words_loaded), 32'd0);

    $display("[TB] gapped valid");
    dutWrites.delete();
    q = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    applyStimulus(q, 1'b1);
    checkOutput("gap_count", 32'(dutWrites.size()), 32'd1);
    checkWrite("gap_w0", 0, 32'h0000_0000, 32'h1234_5678);

    $display("[TB] overflow");
    dutWrites.delete();
    q = '{8'h00, 8'h03, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3,
          8'hC0, 8'hC1, 8'hC2, 8'hC3};
    applyStimulus(q, 1'b0);
    checkOutput("ovf_count", 32'(dutWrites.size()), 32'd2);
    checkWrite("ovf_w0", 0, 32'h0000_0000, 32'hA0A1_A2A3);
    checkWrite("ovf_w1", 1, 32'h0000_0004, 32'hB0B1_B2B3);
    checkOutput("ovf_flag",   32'(lif.overflow),     32'd1);
    checkOutput("ovf_loaded", 32'(lif.words_loaded), 32'd2);

    $display("[TB] reset mid-word");
    dutWrites.delete();
    pulseStart();
    sendByte(8'h00, 1'b0);
    sendByte(8'h01, 1'b0);
    sendByte(8'hDE, 1'b0);
    sendByte(8'hAD, 1'b0);
    rst_n = 1'b0;
    #1 checkAllZero("rst");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("rst_idle_busy", 32'(lif.busy), 32'd0);
    q = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    applyStimulus(q, 1'b0);
    checkOutput("rst_count", 32'(dutWrites.size()), 32'd1);
    checkWrite("rst_w0", 0, BASE, 32'hCAFE_BABE);

    $display("[TB] restart and ignore");
    dutWrites.delete();
    pulseStart();
    sendByte(8'h00, 1'b0);
    sendByte(8'h03, 1'b0);
    sendByte(8'h11, 1'b0);
    lif.start = 1'b1;
    sendByte(8'h22, 1'b0);
    lif.start = 1'b0;
    q = '{8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
    foreach (q[i]) sendByte(q[i], 1'b0);
    waitIdle();
    checkOutput("ign_count",    32'(dutWrites.size()), 32'd2);
    checkWrite("ign_w0", 0, 32'h0000_0000, 32'h1122_3344);
    checkOutput("ign_overflow", 32'(lif.overflow), 32'd1);
    dutWrites.delete();
    pulseStart();
    checkOutput("re_done",     32'(lif.done),         32'd0);
    checkOutput("re_overflow", 32'(lif.overflow),     32'd0);
    checkOutput("re_loaded",   32'(lif.words_loaded), 32'd0);
    checkOutput("re_busy",     32'(lif.busy),         32'd1);
    q = '{8'h00, 8'h01, 8'h0B, 8'hAD, 8'hF0, 8'h0D};
    foreach (q[i]) sendByte(q[i], 1'b0);
    waitIdle();
    checkWrite("re_w0", 0, BASE, 32'h0BAD_F00D);

    $display("[TB] random sessions");
    for (int s = 0; s < 10; s++) begin
      int n;
      n = int'($urandom_range(0, 4));
      q = '{};
      q.push_back(8'h00);
      q.push_back(8'(n));
      for (int k = 0; k < 4 * n; k++) q.push_back(8'($urandom));
      dutWrites.delete();
      applyStimulus(q, 1'($urandom_range(0, 1)));
      checkOutput("rnd_writes",   32'(dutWrites.size()),  32'((n < DEPTH) ? n : DEPTH));
      checkOutput("rnd_overflow", 32'(lif.overflow),      32'(n > DEPTH));
    end

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, is the byte address of the first word written.
REQ-002 Parameter DEPTH, default 256, is the number of writable instruction-memory words.
REQ-003 clk  input  1  rising-edge clock, the only clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  begin a load session; sampled only in IDLE or DONE.
REQ-006 in_data  input  8  serial byte stream.
REQ-007 in_valid  input  1  in_data carries a byte.
REQ-008 in_ready  output  1  loader accepts a byte this cycle.
REQ-009 mem_wr_en  output  1  one-cycle instruction-memory write strobe.
REQ-010 mem_addr  output  32  byte address of the write, always word-aligned.
REQ-011 mem_data  output  32  instruction word to write.
REQ-012 busy  output  1  session in progress; holds the processor off.
REQ-013 done  output  1  session finished; level output.
REQ-014 overflow  output  1  sticky flag: word count exceeded DEPTH.
REQ-015 words_loaded  output  16  count of words actually written this session.

Function
REQ-016 A byte transfer shall occur only on a rising edge where in_valid and in_ready are both 1; in_data is ignored otherwise.
REQ-017 The FSM shall have states IDLE, LEN_HI, LEN_LO, DATA, WRITE and DONE.
REQ-018 IDLE or DONE with start=1 shall go to LEN_HI and clear done, overflow, words_loaded and the internal word index.
REQ-019 in_ready shall be 1 exactly in LEN_HI, LEN_LO and DATA, so there is no combinational path from in_valid to in_ready.
REQ-020 LEN_HI shall capture N[15:8] on transfer and go to LEN_LO.
REQ-021 LEN_LO shall capture N[7:0] on transfer, then go to DONE if N==0, else to DATA.
REQ-022 DATA shall assemble bytes big-endian, first byte to bits [31:24], using a 2-bit byte counter.
REQ-023 The 4th byte transfer shall move the FSM to WRITE and reset the byte counter.
REQ-024 WRITE shall last exactly one cycle, with in_ready=0.
- mem_wr_en=1 only if index < DEPTH.
- mem_addr = BASE_ADDR + 4*index.
- mem_data = the assembled word.
REQ-025 Write latency: mem_wr_en shall assert in the cycle immediately after the 4th-byte transfer edge; peak throughput is 1 word per 5 cycles.
REQ-026 On leaving WRITE, index shall increment (16-bit) and words_loaded shall increment only if a write occurred.
- Next state is DONE if the incremented index == N, else DATA.
REQ-027 If index >= DEPTH in WRITE, the write shall be suppressed and overflow set.
- Remaining words are still consumed so the stream stays aligned.
REQ-028 busy shall be 1 in LEN_HI, LEN_LO, DATA and WRITE, and 0 in IDLE and DONE.
REQ-029 done shall be 1 only in DONE, and held until the next start.
REQ-030 start while busy=1 shall be ignored.
REQ-031 mem_addr and mem_data shall hold their last values outside WRITE; only mem_wr_en qualifies them.
REQ-032 With N=65535 the index shall reach 65535 without wrap, and DONE shall follow the last WRITE.

Reset
REQ-033 rst_n=0 shall immediately force IDLE and clear all of the following to 0: in_ready, mem_wr_en, mem_addr, mem_data, busy, done, overflow, words_loaded, N, index and the byte counter.
REQ-034 Reset mid-session shall discard any partial word, and no write strobe shall follow release.
REQ-035 After rst_n deasserts, the loader shall stay in IDLE until start=1.

Verification
REQ-036 Basic load:
- Stimulus: start, then stream 00 02 | 20 08 00 05 | AC 08 00 04, in_valid held 1.
- Required: writes {0x00, 0x20080005} then {0x04, 0xAC080004}; words_loaded=2; done=1; busy=0.
REQ-037 Zero length:
- Stimulus: start, then 00 00.
- Required: DONE two transfers after start, no mem_wr_en, words_loaded=0.
REQ-038 Gapped valid:
- Stimulus: in_valid toggled 1/0 randomly across one word 12 34 56 78.
- Required: a single write of 0x12345678; no byte lost or duplicated; in_ready=0 in the WRITE cycle.
REQ-039 Overflow:
- Stimulus: DEPTH=2, N=3, words A, B, C.
- Required: A and B written at 0x00 and 0x04, C consumed without a write; overflow=1; words_loaded=2; done=1.
REQ-040 Reset mid-word:
- Stimulus: rst_n low after 2 data bytes, released, then start and a complete 1-word stream.
- Required: all outputs 0 during reset; the new word is written at BASE_ADDR with no stray write.
REQ-041 Restart and ignore:
- Stimulus: start pulsed while busy, then a new start in DONE.
- Required: the busy-time start has no effect; the new start clears done, overflow and words_loaded, and index restarts at BASE_ADDR.
